// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: requester 0 gets priority, capped by a streak limit;
// the other requesters are served round-robin. A watchdog aborts stalled accesses.
module mem_port_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDR_W        = 32,
  parameter int MAX_HI_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_rdata
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = $clog2(MAX_HI_STREAK + 1);
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nxt;

  logic [GW-1:0] grant, rr_ptr, lo_win, win;
  logic [SW-1:0] hi_streak;
  logic [CW-1:0] tcnt;
  logic          err_q, any_lo, hi_win, tmo;
  int            rr_c;

  assign any_lo = |req_valid[NUM_REQ-1:1];
  assign hi_win = req_valid[0] && !((32'(hi_streak) == MAX_HI_STREAK) && any_lo);
  assign win    = hi_win ? '0 : lo_win;
  assign tmo    = (TIMEOUT != 0) && ((32'(tcnt) + 32'd1) == 32'(TIMEOUT));

  // Scan low requesters from rr_ptr+1 with wrap over 1..NUM_REQ-1; smallest offset wins.
  always_comb begin
    lo_win = '0;
    rr_c   = 0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      rr_c = int'(rr_ptr) + k;
      if (rr_c >= NUM_REQ) rr_c = rr_c - (NUM_REQ - 1);
      if (req_valid[GW'(rr_c)]) lo_win = GW'(rr_c);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = BUSY;
      BUSY:    if (mem_ready || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_done = '0;
    if (state == RESP) req_done[grant] = 1'b1;
  end
  assign rsp_err = err_q && (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      hi_streak <= '0;
      tcnt      <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_rdata <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (|req_valid) begin
            grant     <= win;
            mem_valid <= 1'b1;
            mem_addr  <= req_addr[win*ADDR_W +: ADDR_W];
            mem_we    <= req_we[win];
            mem_wdata <= req_wdata[win*32 +: 32];
            mem_wstrb <= req_wstrb[win*4 +: 4];
            if (hi_win) begin
              if (32'(hi_streak) < MAX_HI_STREAK) hi_streak <= hi_streak + 1'b1;
            end else begin
              rr_ptr    <= lo_win;
              hi_streak <= '0;
            end
          end
        end
        BUSY: begin
          tcnt <= tcnt + 1'b1;
          // A ready arriving on the timeout cycle still completes normally.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            rsp_rdata <= mem_we ? 32'd0 : mem_rdata;
            err_q     <= 1'b0;
          end else if (tmo) begin
            mem_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            err_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions
// plus hand sequences for streak limit, round-robin, and reset mid-transaction.
module tb_mem_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_done;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [31:0]     rsp_rdata, mem_wdata, mem_rdata;
  logic            rsp_err, mem_valid, mem_we, mem_ready;
  logic [AW-1:0]   mem_addr;
  logic [3:0]      mem_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .MAX_HI_STREAK(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_done(req_done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Fixed per-requester fields for the whole run.
  logic [31:0] f_addr  [N] = '{32'h40, 32'h100, 32'h2000};
  logic        f_we    [N] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] f_wdata [N] = '{32'h5555_5555, 32'h1111_0000, 32'h1234_5678};
  logic [3:0]  f_wstrb [N] = '{4'b1000, 4'b1111, 4'b0011};

  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0]  v;
    int          wait_n;
    logic [31:0] rd;
    int          g;
    logic [31:0] rdata;
    logic        err;
    int          busy;
  } vec_t;
  vec_t vecs[9];

  logic [2:0]  t_done;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_wstrb;
  logic        t_we, t_err, t_got, t_stable, t_gap_ok;
  int          t_busy;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] v, int w, logic [31:0] rd, int g,
                              logic [31:0] rdata, logic err, int busy);
    vec_t r;
    r.v = v; r.wait_n = w; r.rd = rd; r.g = g; r.rdata = rdata; r.err = err; r.busy = busy;
    return r;
  endfunction

  function automatic int idx_of(logic [2:0] d);
    return d == 3'b001 ? 0 : d == 3'b010 ? 1 : d == 3'b100 ? 2 : -1;
  endfunction

  // Drives one transaction; memory answers on the wait_n-th BUSY cycle (0 = never).
  task automatic txn(input logic [2:0] v, input int wait_n, input logic [31:0] rd, input bit drop);
    int rdy_iter;
    req_valid = v; t_got = 0; t_busy = 0; t_stable = 1; t_gap_ok = 0; rdy_iter = -10; t_done = '0;
    for (int c = 0; c < 300 && !t_got; c++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      if (req_done != '0) begin
        t_got = 1; t_done = req_done; t_rdata = rsp_rdata; t_err = rsp_err;
        t_gap_ok = (wait_n == 0) || (c == rdy_iter + 1);
        chk("mem_valid_in_resp", mem_valid, 0);
        if (drop) req_valid = '0;
      end else if (mem_valid) begin
        t_busy++;
        if (t_busy == 1) begin
          t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata; t_wstrb = mem_wstrb;
        end else if ({mem_addr, mem_we, mem_wdata, mem_wstrb} !== {t_addr, t_we, t_wdata, t_wstrb})
          t_stable = 0;
        if (t_busy == wait_n) begin mem_ready = 1'b1; mem_rdata = rd; rdy_iter = c; end
      end
    end
    chk("txn_completes", t_got, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int gl, run, run_max;
    int exp_p[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int exp_r[4]  = '{1, 2, 1, 2};
    logic seen;

    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = f_addr[i];
      req_we[i]            = f_we[i];
      req_wdata[i*32 +: 32] = f_wdata[i];
      req_wstrb[i*4 +: 4]   = f_wstrb[i];
    end
    reset = 1'b1; req_valid = '0; mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b0;

    vecs[0] = mk(3'b010, 3,  32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 3);
    vecs[1] = mk(3'b100, 2,  32'hCAFE_F00D, 2, 32'h0,         0, 2);
    vecs[2] = mk(3'b001, 1,  32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, 1);
    vecs[3] = mk(3'b110, 1,  32'h0000_0001, 1, 32'h0000_0001, 0, 1);
    vecs[4] = mk(3'b110, 1,  32'h0000_0002, 2, 32'h0,         0, 1);
    vecs[5] = mk(3'b110, 1,  32'h0000_0003, 1, 32'h0000_0003, 0, 1);
    vecs[6] = mk(3'b001, 0,  32'h0,         0, 32'h0,         1, 64);
    vecs[7] = mk(3'b001, 64, 32'h6464_6464, 0, 32'h6464_6464, 0, 64);
    vecs[8] = mk(3'b011, 1,  32'h0000_0009, 0, 32'h0000_0009, 0, 1);

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].v, vecs[i].wait_n, vecs[i].rd, 1);
      gl = vecs[i].g;
      chk($sformatf("v%0d_done", i), t_done, 32'(1) << gl);
      chk($sformatf("v%0d_addr", i), t_addr, f_addr[gl]);
      chk($sformatf("v%0d_we", i), t_we, f_we[gl]);
      chk($sformatf("v%0d_wdata", i), t_wdata, f_wdata[gl]);
      chk($sformatf("v%0d_wstrb", i), t_wstrb, f_wstrb[gl]);
      chk($sformatf("v%0d_rdata", i), t_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), t_err, vecs[i].err);
      chk($sformatf("v%0d_busy_cycles", i), t_busy, vecs[i].busy);
      chk($sformatf("v%0d_fields_stable", i), t_stable, 1);
      chk($sformatf("v%0d_done_gap", i), t_gap_ok, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), req_done, 0);
      chk($sformatf("v%0d_err_after", i), rsp_err, 0);
      chk($sformatf("v%0d_rdata_hold", i), rsp_rdata, vecs[i].rdata);
    end

    // Streak limit: everyone pending, requester 0 capped at 4 in a row.
    do_reset();
    run = 0; run_max = 0;
    for (int i = 0; i < 10; i++) begin
      txn(3'b111, 1, 32'(i), 0);
      gl = idx_of(t_done);
      chk($sformatf("prio_grant%0d", i), gl, exp_p[i]);
      run = (gl == 0) ? run + 1 : 0;
      if (run > run_max) run_max = run;
    end
    req_valid = '0;
    chk("prio_max_hi_run", run_max, 4);
    repeat (2) @(posedge clk);
    #1;

    // Round-robin among low requesters, first grant to 1 after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(3'b110, 1, 32'(i), 0);
      chk($sformatf("rr_grant%0d", i), idx_of(t_done), exp_r[i]);
    end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while BUSY abandons the transfer and restores rr_ptr.
    do_reset();
    txn(3'b010, 1, 32'h1, 1);
    chk("mid_pre_grant", idx_of(t_done), 1);
    req_valid = 3'b110;
    for (int c = 0; c < 5 && !mem_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_busy_valid", mem_valid, 1);
    chk("mid_busy_addr", mem_addr, 32'h2000);
    reset = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_mem_valid", mem_valid, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | (|req_done);
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", seen, 0);
    txn(3'b110, 2, 32'h7777_0000, 1);
    chk("mid_post_grant", t_done, 3'b010);
    chk("mid_post_rdata", t_rdata, 32'h7777_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
